// File: rtl/vx_ibuffer_scoreboard_pkg.sv
// Shared types and widths for the instruction-buffer scoreboard slice.
// The instruction record carried from the ibuffer, the warp-tagged record
// handed to the operand collector, and register/perf counter widths.
// Optional feature macro used by this slice: SCOREBOARD_PERF_EN.
package vx_ibuffer_scoreboard_pkg;

    localparam int NUM_ISSUE_WARPS = 4;
    localparam int ISSUE_WIS_W     = $clog2(NUM_ISSUE_WARPS);
    localparam int NR_BITS         = 5;
    localparam int NUM_REGS        = 2 ** NR_BITS;
    localparam int UUID_BITS       = 16;
    localparam int OP_BITS         = 4;
    localparam int PERF_CTR_BITS   = 16;

    // Head-of-buffer instruction as seen by the scoreboard.
    typedef struct packed {
        logic [UUID_BITS-1:0] uuid;
        logic [OP_BITS-1:0]   op_type;
        logic                 wb;
        logic [NR_BITS-1:0]   rd;
        logic [NR_BITS-1:0]   rs1;
        logic [NR_BITS-1:0]   rs2;
        logic [NR_BITS-1:0]   rs3;
    } ibuffer_data_t;

    // Issued instruction tagged with the warp it came from.
    typedef struct packed {
        logic [ISSUE_WIS_W-1:0] wid;
        ibuffer_data_t          data;
    } issue_data_t;

    // True when the instruction will produce a register that must be tracked.
    // Register 0 is hardwired and never becomes busy.
    function automatic logic writes_reg(input ibuffer_data_t d);
        return d.wb && (d.rd != '0);
    endfunction

endpackage

// File: rtl/vx_ibuffer_if.sv
// Per-warp instruction buffer handshake: the buffer offers its head
// instruction with valid, the scoreboard accepts it with ready.
interface vx_ibuffer_if;
    import vx_ibuffer_scoreboard_pkg::*;

    logic          valid;
    ibuffer_data_t data;
    logic          ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_ibuffer_scoreboard_elastic_buffer.sv
// Output stage of the scoreboard: a valid/ready elastic buffer.
// SIZE=1 is a plain pipe register whose input ready depends on the
// downstream ready; SIZE>=2 is a two-entry skid buffer whose input ready
// is purely registered, giving full throughput without a combinational
// ready path back into the arbiter.
module vx_ibuffer_scoreboard_elastic_buffer #(
    parameter int SIZE  = 2,
    parameter int DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    if (SIZE == 1) begin : g_pipe

        logic             pipe_valid;
        logic [DATAW-1:0] pipe_data;

        assign ready_in  = ~pipe_valid | ready_out;
        assign valid_out = pipe_valid;
        assign data_out  = pipe_data;

        // Load a new entry whenever the register is empty or being drained.
        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_valid <= 1'b0;
            end else if (ready_in) begin
                pipe_valid <= valid_in;
                if (valid_in) begin
                    pipe_data <= data_in;
                end
            end
        end

    end else begin : g_skid

        logic             main_valid;
        logic [DATAW-1:0] main_data;
        logic             skid_valid;
        logic [DATAW-1:0] skid_data;

        assign ready_in  = ~skid_valid;
        assign valid_out = main_valid;
        assign data_out  = main_data;

        // Main register feeds the output; the skid register catches the one
        // entry that arrives in the cycle the output first stalls.
        always_ff @(posedge clk) begin
            if (reset) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (skid_valid) begin
                if (ready_out) begin
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end
            end else if (main_valid && !ready_out) begin
                if (valid_in) begin
                    skid_data  <= data_in;
                    skid_valid <= 1'b1;
                end
            end else begin
                main_valid <= valid_in;
                if (valid_in) begin
                    main_data <= data_in;
                end
            end
        end

    end

endmodule

// File: rtl/vx_ibuffer_scoreboard.sv
// Scoreboard and issue arbiter for one slice of issue warps.
// Each warp's head instruction is checked against that warp's register
// in-use table; one hazard-free warp per cycle is picked round-robin and
// forwarded, tagged with its warp id, through a registered output stage.
// Writebacks release busy registers one cycle before dependants may issue.
// Optional macro SCOREBOARD_PERF_EN adds the perf_stalls hazard counter.
module vx_ibuffer_scoreboard
    import vx_ibuffer_scoreboard_pkg::*;
#(
    parameter int PER_ISSUE_WARPS = NUM_ISSUE_WARPS,
    parameter int OUT_BUF         = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    vx_ibuffer_if.slave                        ibuffer_if [PER_ISSUE_WARPS],
    output logic                               out_valid,
    output logic [$clog2(PER_ISSUE_WARPS)-1:0] out_wid,
    output ibuffer_data_t                      out_data,
    input  logic                               out_ready,
    input  logic                               wb_valid,
    input  logic [$clog2(PER_ISSUE_WARPS)-1:0] wb_wid,
    input  logic [NR_BITS-1:0]                 wb_rd
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]           perf_stalls
`endif
);

    localparam int WID_W = $clog2(PER_ISSUE_WARPS);
    localparam int DATAW = WID_W + $bits(ibuffer_data_t);

    logic [PER_ISSUE_WARPS-1:0]                valid_vec;
    ibuffer_data_t                             data_vec [PER_ISSUE_WARPS];
    logic [PER_ISSUE_WARPS-1:0]                hazard;
    logic [PER_ISSUE_WARPS-1:0]                candidate;
    logic [PER_ISSUE_WARPS-1:0]                grant;
    logic [PER_ISSUE_WARPS-1:0][NUM_REGS-1:0]  inuse;

    logic [WID_W-1:0]  rr_ptr;
    logic [WID_W-1:0]  rr_idx;
    logic [WID_W-1:0]  grant_wid;
    logic              grant_any;
    logic              buf_ready;
    ibuffer_data_t     fire_data;
    logic              fire_sets;
    logic [DATAW-1:0]  buf_in;
    logic [DATAW-1:0]  buf_out;

    // Per-warp view of the ibuffer handshake and the hazard check against
    // that warp's own in-use table. A destination only matters when the
    // instruction writes back (write-after-write ordering).
    for (genvar g = 0; g < PER_ISSUE_WARPS; g++) begin : g_warp
        assign valid_vec[g]        = ibuffer_if[g].valid;
        assign data_vec[g]         = ibuffer_if[g].data;
        assign ibuffer_if[g].ready = grant[g];

        assign hazard[g] = valid_vec[g]
                         & ( inuse[g][data_vec[g].rs1]
                           | inuse[g][data_vec[g].rs2]
                           | inuse[g][data_vec[g].rs3]
                           | (data_vec[g].wb & inuse[g][data_vec[g].rd]) );

        assign candidate[g] = valid_vec[g] & ~hazard[g];
    end

    // Round-robin pick starting one past the last granted warp; the last
    // granted warp itself is checked last so every ready warp gets a turn.
    // Nothing is granted in reset or when the output stage cannot accept.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_wid = rr_ptr;
        rr_idx    = rr_ptr;
        if (!reset && buf_ready) begin
            for (int i = 1; i <= PER_ISSUE_WARPS; i++) begin
                rr_idx = rr_ptr + WID_W'(i);
                if (!grant_any && candidate[rr_idx]) begin
                    grant_any = 1'b1;
                    grant_wid = rr_idx;
                end
            end
            if (grant_any) begin
                grant[grant_wid] = 1'b1;
            end
        end
    end

    assign fire_data = data_vec[grant_wid];
    assign fire_sets = grant_any & writes_reg(fire_data);

    // Remember the last granted warp so priority rotates past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= grant_wid;
        end
    end

    // Busy-register table: writeback clears, issue sets. The set is applied
    // after the clear so a new producer wins over a retiring one.
    always_ff @(posedge clk) begin
        if (reset) begin
            inuse <= '0;
        end else begin
            if (wb_valid) begin
                inuse[wb_wid][wb_rd] <= 1'b0;
            end
            if (fire_sets) begin
                inuse[grant_wid][fire_data.rd] <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // A writeback should only retire a register that is actually busy,
    // except when it coincides with a new producer of the same register.
    always_ff @(posedge clk) begin
        if (!reset && wb_valid
            && !(fire_sets && grant_wid == wb_wid && fire_data.rd == wb_rd)) begin
            assert (inuse[wb_wid][wb_rd])
            else $error("scoreboard: writeback to a register that is not busy");
        end
    end
`endif

    assign buf_in = {grant_wid, fire_data};

    vx_ibuffer_scoreboard_elastic_buffer #(
        .SIZE  (OUT_BUF),
        .DATAW (DATAW)
    ) out_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (grant_any),
        .ready_in  (buf_ready),
        .data_in   (buf_in),
        .valid_out (out_valid),
        .ready_out (out_ready),
        .data_out  (buf_out)
    );

    assign {out_wid, out_data} = buf_out;

`ifdef SCOREBOARD_PERF_EN
    logic [PERF_CTR_BITS-1:0] stall_ctr;

    // Count cycles where work is waiting but every waiting warp is blocked
    // by a register hazard; output backpressure is deliberately excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_ctr <= '0;
        end else if ((|valid_vec) && !(|candidate)) begin
            stall_ctr <= stall_ctr + PERF_CTR_BITS'(1);
        end
    end

    assign perf_stalls = stall_ctr;
`endif

endmodule

// File: tb/tb_vx_ibuffer_scoreboard.sv
// Self-checking bench for vx_ibuffer_scoreboard: per-warp instruction
// queues feed the ibuffer interfaces, a reference model predicts grants
// and pushes expected issued records into a scoreboard queue that is
// compared against the output port, plus directed checks for each scenario.
module tb_vx_ibuffer_scoreboard;
    import vx_ibuffer_scoreboard_pkg::*;

    localparam int NW      = 4;
    localparam int WID_W   = 2;
    localparam int OUT_BUF = 2;
    localparam int QD      = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 out_valid;
    logic [WID_W-1:0]     out_wid;
    ibuffer_data_t        out_data;
    logic                 out_ready;
    logic                 wb_valid;
    logic [WID_W-1:0]     wb_wid;
    logic [NR_BITS-1:0]   wb_rd;
`ifdef SCOREBOARD_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls;
`endif

    logic [NW-1:0]        tb_valid;
    logic [NW-1:0]        tb_ready;
    ibuffer_data_t        tb_data [NW];

    int checks   = 0;
    int failures = 0;

    // Instruction sources, one small FIFO per warp.
    ibuffer_data_t wmem  [NW][QD];
    int            whead [NW];
    int            wtail [NW];

    // Reference model state.
    logic [NUM_REGS-1:0]      m_inuse [NW];
    int                       m_rr;
    int                       m_gidx;
    logic [PERF_CTR_BITS-1:0] m_perf;
    logic [63:0]              expq [$];
    int                       obs_wid [$];

    // Values sampled at the most recent negedge for directed checks.
    logic [NW-1:0]            last_ready;
    logic                     last_out_valid;
    logic [63:0]              last_item;
    logic [PERF_CTR_BITS-1:0] last_perf;

    always #5 clk = ~clk;

    vx_ibuffer_if ibuf_if [NW] ();

    for (genvar g = 0; g < NW; g++) begin : g_src
        assign ibuf_if[g].valid = tb_valid[g];
        assign ibuf_if[g].data  = tb_data[g];
        assign tb_ready[g]      = ibuf_if[g].ready;
    end

    vx_ibuffer_scoreboard #(
        .PER_ISSUE_WARPS (NW),
        .OUT_BUF         (OUT_BUF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ibuffer_if (ibuf_if),
        .out_valid  (out_valid),
        .out_wid    (out_wid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .wb_valid   (wb_valid),
        .wb_wid     (wb_wid),
        .wb_rd      (wb_rd)
`ifdef SCOREBOARD_PERF_EN
        ,
        .perf_stalls (perf_stalls)
`endif
    );

    function automatic ibuffer_data_t mk(input logic [15:0] uuid, input logic wb,
                                         input int rd, input int rs1, input int rs2, input int rs3);
        ibuffer_data_t d;
        d.uuid    = uuid;
        d.op_type = uuid[3:0];
        d.wb      = wb;
        d.rd      = NR_BITS'(rd);
        d.rs1     = NR_BITS'(rs1);
        d.rs2     = NR_BITS'(rs2);
        d.rs3     = NR_BITS'(rs3);
        return d;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int w = 0; w < NW; w++) begin
            tb_valid[w] = (whead[w] < wtail[w]);
            tb_data[w]  = tb_valid[w] ? wmem[w][whead[w]] : '0;
        end
    endtask

    task automatic push_instr(input int w, input ibuffer_data_t d);
        wmem[w][wtail[w]] = d;
        wtail[w]++;
        refresh();
    endtask

    task automatic clear_warps();
        for (int w = 0; w < NW; w++) begin
            whead[w] = 0;
            wtail[w] = 0;
        end
        refresh();
    endtask

    task automatic apply_stimulus_wb(input int w, input int rd);
        wb_valid = 1'b1;
        wb_wid   = WID_W'(w);
        wb_rd    = NR_BITS'(rd);
    endtask

    // One clock: predict and compare at negedge, advance model at posedge.
    task automatic apply_stimulus();
        logic [NW-1:0] cand;
        logic [NW-1:0] gnt;
        logic          brdy;
        logic          pop;
        ibuffer_data_t d;
        refresh();
        @(negedge clk);
        cand = '0;
        for (int w = 0; w < NW; w++) begin
            if (tb_valid[w]) begin
                d = tb_data[w];
                if (!(m_inuse[w][d.rs1] || m_inuse[w][d.rs2] || m_inuse[w][d.rs3]
                      || (d.wb && m_inuse[w][d.rd]))) begin
                    cand[w] = 1'b1;
                end
            end
        end
        brdy = (OUT_BUF == 1) ? (expq.size() == 0 || out_ready) : (expq.size() < OUT_BUF);
        m_gidx = -1;
        gnt    = '0;
        if (!reset && brdy) begin
            for (int i = 1; i <= NW; i++) begin
                if (m_gidx < 0 && cand[(m_rr + i) % NW]) m_gidx = (m_rr + i) % NW;
            end
        end
        if (m_gidx >= 0) gnt[m_gidx] = 1'b1;
        check_output("ready", 64'(tb_ready), 64'(gnt));
        check_output("out_valid", 64'(out_valid), 64'(expq.size() != 0));
        if (out_valid && expq.size() != 0) begin
            check_output("out_item", 64'({out_wid, out_data}), expq[0]);
        end
`ifdef SCOREBOARD_PERF_EN
        check_output("perf_stalls", 64'(perf_stalls), 64'(m_perf));
        last_perf = perf_stalls;
`endif
        last_ready     = tb_ready;
        last_out_valid = out_valid;
        last_item      = 64'({out_wid, out_data});
        if (out_valid && out_ready) obs_wid.push_back(int'(out_wid));
        @(posedge clk);
        if (reset) begin
            for (int w = 0; w < NW; w++) m_inuse[w] = '0;
            m_rr   = 0;
            m_perf = '0;
            expq.delete();
        end else begin
            pop = (expq.size() != 0) && out_ready;
            if (pop) void'(expq.pop_front());
            if (wb_valid) m_inuse[wb_wid][wb_rd] = 1'b0;
            if (m_gidx >= 0) begin
                d = wmem[m_gidx][whead[m_gidx]];
                if (d.wb && d.rd != '0) m_inuse[m_gidx][d.rd] = 1'b1;
                m_rr = m_gidx;
                expq.push_back(64'({WID_W'(m_gidx), d}));
                whead[m_gidx]++;
            end
            if ((|tb_valid) && cand == '0) m_perf = m_perf + PERF_CTR_BITS'(1);
        end
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic check_drained(input string tag);
        int left;
        left = expq.size();
        for (int w = 0; w < NW; w++) left += wtail[w] - whead[w];
        check_output(tag, 64'(left), 64'd0);
    endtask

    initial begin
        int accepted;
        logic [63:0] snap;
        reset     = 1'b1;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_wid    = '0;
        wb_rd     = '0;
        m_rr      = 0;
        m_perf    = '0;
        for (int w = 0; w < NW; w++) m_inuse[w] = '0;
        clear_warps();

        $display("[TB] reset with all warps valid");
        for (int w = 0; w < NW; w++) push_instr(w, mk(16'h0100 + 16'(w), 1'b0, 0, w + 1, 0, 0));
        for (int k = 0; k < 2; k++) begin
            apply_stimulus();
            check_output("reset_ready", 64'(last_ready), 64'd0);
            check_output("reset_out_valid", 64'(last_out_valid), 64'd0);
        end
        reset = 1'b0;
        apply_stimulus();
        check_output("first_grant", 64'(last_ready), 64'b0010);
        run_cycles(6);
        check_drained("reset_drain");

        $display("[TB] read-after-write on warp 0");
        push_instr(0, mk(16'h0200, 1'b1, 5, 0, 0, 0));
        push_instr(0, mk(16'h0201, 1'b1, 6, 5, 0, 0));
        apply_stimulus();
        check_output("raw_producer", 64'(last_ready), 64'b0001);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus();
            check_output("raw_stall", 64'(last_ready), 64'd0);
        end
        apply_stimulus_wb(0, 5);
        apply_stimulus();
        check_output("raw_wb_cycle", 64'(last_ready), 64'd0);
        apply_stimulus();
        check_output("raw_release", 64'(last_ready), 64'b0001);
        apply_stimulus_wb(0, 6);
        run_cycles(3);
        check_drained("raw_drain");

        $display("[TB] write-after-write on warp 2");
        push_instr(2, mk(16'h0300, 1'b1, 7, 0, 0, 0));
        push_instr(2, mk(16'h0301, 1'b1, 7, 0, 0, 0));
        push_instr(2, mk(16'h0302, 1'b1, 0, 0, 0, 0));
        apply_stimulus();
        check_output("waw_first", 64'(last_ready), 64'b0100);
        for (int k = 0; k < 2; k++) begin
            apply_stimulus();
            check_output("waw_stall", 64'(last_ready), 64'd0);
        end
        apply_stimulus_wb(2, 7);
        apply_stimulus();
        check_output("waw_wb_cycle", 64'(last_ready), 64'd0);
        apply_stimulus();
        check_output("waw_release", 64'(last_ready), 64'b0100);
        apply_stimulus();
        check_output("rd0_no_stall", 64'(last_ready), 64'b0100);
        apply_stimulus_wb(2, 7);
        run_cycles(3);
        check_drained("waw_drain");

        $display("[TB] round-robin fairness");
        reset = 1'b1;
        clear_warps();
        apply_stimulus();
        reset = 1'b0;
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < 3; k++) push_instr(w, mk(16'h0400 + 16'(w * 16 + k), 1'b0, 0, k + 1, 0, 0));
        end
        obs_wid.delete();
        apply_stimulus();
        for (int k = 1; k <= 12; k++) begin
            apply_stimulus();
            check_output("throughput", 64'(last_out_valid), 64'd1);
        end
        check_output("fair_count", 64'(obs_wid.size()), 64'd12);
        for (int k = 0; k < obs_wid.size(); k++) begin
            check_output("fair_order", 64'(obs_wid[k]), 64'((k + 1) % NW));
        end
        run_cycles(2);
        check_drained("fair_drain");

        $display("[TB] output backpressure");
        obs_wid.delete();
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < 2; k++) push_instr(w, mk(16'h0500 + 16'(w * 16 + k), 1'b0, 0, 0, k + 2, 0));
        end
        out_ready = 1'b0;
        accepted  = 0;
        snap      = '0;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus();
            accepted += $countones(last_ready);
            if (k == 1) snap = last_item;
            if (k > 1) check_output("bp_stable", last_item, snap);
        end
        check_output("bp_accepted", 64'(accepted), 64'(OUT_BUF));
        out_ready = 1'b1;
        run_cycles(12);
        check_output("bp_delivered", 64'(obs_wid.size()), 64'd8);
        check_drained("bp_drain");

        $display("[TB] set/clear collision");
        reset = 1'b1;
        clear_warps();
        apply_stimulus();
        reset = 1'b0;
        push_instr(1, mk(16'h0600, 1'b1, 9, 0, 0, 0));
        push_instr(1, mk(16'h0601, 1'b0, 0, 9, 0, 0));
        apply_stimulus_wb(1, 9);
        apply_stimulus();
        check_output("collision_fire", 64'(last_ready), 64'b0010);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus();
            check_output("collision_busy", 64'(last_ready), 64'd0);
        end
        apply_stimulus_wb(1, 9);
        apply_stimulus();
`ifdef SCOREBOARD_PERF_EN
        check_output("perf_three", 64'(last_perf), 64'd3);
`endif
        apply_stimulus();
        check_output("collision_release", 64'(last_ready), 64'b0010);
        run_cycles(3);
        check_drained("collision_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
